nw_traceback: RTL and testbench

- Downstream consumer of the direction RAM in the Needleman-Wunsch datapath.
- After the fill phase completes, it walks the (N+1)x(N+1) direction matrix from cell (N,N) back to (0,0).
- Issues one RAM read per step and decodes the 3-bit direction code.
- Emits one alignment step per move over a valid/ready handshake to the alignment output stage.

---
 rtl/nw_pkg.sv | 29 ++
 rtl/nw_dir_decode.sv | 32 +++
 rtl/nw_traceback.sv | 155 +++++++++++++++
 tb/tb_nw_traceback.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nw_pkg.sv
// Shared definitions for the Needleman-Wunsch traceback path:
// direction-code bit positions, step opcodes, FSM states and sizing helper.
package nw_pkg;

  // Bit positions inside the 3-bit direction code (independent flags)
  localparam int DIR_DIAG = 0;
  localparam int DIR_UP   = 1;
  localparam int DIR_LEFT = 2;

  typedef enum logic [1:0] {
    OP_DIAG = 2'd0,
    OP_UP   = 2'd1,
    OP_LEFT = 2'd2
  } step_op_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READ   = 3'd1,
    S_DECIDE = 3'd2,
    S_EMIT   = 3'd3,
    S_FINISH = 3'd4
  } tb_state_e;

  // Address width of an (n+1)x(n+1) direction matrix
  function automatic int addr_width(input int n);
    return $clog2((n + 1) * (n + 1));
  endfunction

endpackage

// File: rtl/nw_dir_decode.sv
// Combinational direction decoder: forces the move along the matrix edges,
// otherwise picks DIAG > UP > LEFT from the flag bits and flags an empty code.
module nw_dir_decode
  import nw_pkg::*;
(
  input  logic [2:0] dir_i,
  input  logic       i_zero_i,
  input  logic       j_zero_i,
  output step_op_e   op_o,
  output logic       invalid_o
);

  // Edge forcing first, then priority decode of the flag bits
  always_comb begin
    op_o      = OP_DIAG;
    invalid_o = 1'b0;
    if (i_zero_i) begin
      op_o = OP_LEFT;
    end else if (j_zero_i) begin
      op_o = OP_UP;
    end else if (dir_i[DIR_DIAG]) begin
      op_o = OP_DIAG;
    end else if (dir_i[DIR_UP]) begin
      op_o = OP_UP;
    end else if (dir_i[DIR_LEFT]) begin
      op_o = OP_LEFT;
    end else begin
      invalid_o = 1'b1;
    end
  end

endmodule

// File: rtl/nw_traceback.sv
// Needleman-Wunsch traceback walker: reads the direction RAM from (N,N)
// back to (0,0) and hands out one alignment step per move over valid/ready.
// The RAM address follows the walk by incremental subtraction only.
module nw_traceback
  import nw_pkg::*;
#(
  parameter int N      = 128,
  parameter int ADDR_W = addr_width(N),
  parameter int IDX_W  = $clog2(N + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              en_dout,
  output logic [ADDR_W-1:0] addr_dout,
  input  logic [2:0]        dout,
  output logic              step_valid,
  input  logic              step_ready,
  output logic [1:0]        step_op,
  output logic [IDX_W-1:0]  step_i,
  output logic [IDX_W-1:0]  step_j,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'((N + 1) * (N + 1) - 1);
  localparam logic [ADDR_W-1:0] DEC_DIAG  = ADDR_W'(N + 2);
  localparam logic [ADDR_W-1:0] DEC_UP    = ADDR_W'(N + 1);
  localparam logic [ADDR_W-1:0] DEC_LEFT  = ADDR_W'(1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N);
  localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);

  tb_state_e         state_q, state_d;
  logic [IDX_W-1:0]  i_q, i_d;
  logic [IDX_W-1:0]  j_q, j_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  step_op_e          op_q, op_d;
  logic [IDX_W-1:0]  si_q, si_d;
  logic [IDX_W-1:0]  sj_q, sj_d;
  logic              err_q, err_d;

  step_op_e          dec_op;
  logic              dec_invalid;

  nw_dir_decode u_dec (
    .dir_i     (dout),
    .i_zero_i  (i_q == '0),
    .j_zero_i  (j_q == '0),
    .op_o      (dec_op),
    .invalid_o (dec_invalid)
  );

  // State, walk position, address and held step registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      addr_q  <= '0;
      op_q    <= OP_DIAG;
      si_q    <= '0;
      sj_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      addr_q  <= addr_d;
      op_q    <= op_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic: one read, one decide, one emit per move
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    addr_d  = addr_q;
    op_d    = op_q;
    si_d    = si_q;
    sj_d    = sj_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          i_d     = IDX_LAST;
          j_d     = IDX_LAST;
          addr_d  = ADDR_LAST;
          err_d   = 1'b0;
          state_d = S_READ;
        end
      end
      S_READ: begin
        state_d = S_DECIDE;
      end
      S_DECIDE: begin
        if (dec_invalid) begin
          err_d   = 1'b1;
          state_d = S_FINISH;
        end else begin
          op_d    = dec_op;
          si_d    = i_q;
          sj_d    = j_q;
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        if (step_ready) begin
          case (op_q)
            OP_DIAG: begin
              i_d    = i_q - IDX_ONE;
              j_d    = j_q - IDX_ONE;
              addr_d = addr_q - DEC_DIAG;
            end
            OP_UP: begin
              i_d    = i_q - IDX_ONE;
              addr_d = addr_q - DEC_UP;
            end
            OP_LEFT: begin
              j_d    = j_q - IDX_ONE;
              addr_d = addr_q - DEC_LEFT;
            end
            default: begin
            end
          endcase
          state_d = ((i_d == '0) && (j_d == '0)) ? S_FINISH : S_READ;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from the registered state
  always_comb begin
    en_dout    = (state_q == S_READ);
    addr_dout  = (state_q == S_READ) ? addr_q : '0;
    step_valid = (state_q == S_EMIT);
    step_op    = op_q;
    step_i     = si_q;
    step_j     = sj_q;
    busy       = (state_q == S_READ) || (state_q == S_DECIDE) || (state_q == S_EMIT);
    done       = (state_q == S_FINISH);
    error      = err_q;
  end

endmodule

// File: tb/tb_nw_traceback.sv
// Directed bench for nw_traceback with N=4 and a one-cycle-latency RAM model.
module tb_nw_traceback;
  localparam int N      = 4;
  localparam int ADDR_W = 5;
  localparam int IDX_W  = 3;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              en_dout;
  logic [ADDR_W-1:0] addr_dout;
  logic [2:0]        dout;
  logic              step_valid;
  logic              step_ready;
  logic [1:0]        step_op;
  logic [IDX_W-1:0]  step_i;
  logic [IDX_W-1:0]  step_j;
  logic              busy;
  logic              done;
  logic              error;

  nw_traceback #(.N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .en_dout    (en_dout),
    .addr_dout  (addr_dout),
    .dout       (dout),
    .step_valid (step_valid),
    .step_ready (step_ready),
    .step_op    (step_op),
    .step_i     (step_i),
    .step_j     (step_j),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Direction RAM model: data appears the cycle after the read enable
  logic [2:0] mem [0:24];
  always @(posedge clk) begin
    if (en_dout) dout <= mem[addr_dout];
  end

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) pass_cnt = pass_cnt + 1;
    else begin
      fail_cnt = fail_cnt + 1;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic [2:0] v);
    for (int a = 0; a < 25; a++) mem[a] = v;
  endtask

  // Results of the most recent walk
  int acc_op[$];
  int acc_i[$];
  int acc_j[$];
  int acc_k[$];
  int rd_addr[$];
  int first_en_k, first_valid_k, done_k;
  logic err_k1, err_done;

  // Pulse start, then follow the walk cycle by cycle until done or budget
  task automatic walk(input int stall, input int restart_k);
    int stall_left;
    logic [1:0] h_op;
    logic [IDX_W-1:0] h_i, h_j;
    acc_op.delete(); acc_i.delete(); acc_j.delete(); acc_k.delete(); rd_addr.delete();
    first_en_k = -1; first_valid_k = -1; done_k = -1;
    err_k1 = 1'b0; err_done = 1'b0;
    stall_left = stall;
    h_op = '0; h_i = '0; h_j = '0;
    @(negedge clk);
    start = 1'b1;
    step_ready = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      @(posedge clk);
      @(negedge clk);
      start = (k == restart_k);
      if (k == 1) err_k1 = error;
      if (en_dout) begin
        rd_addr.push_back(int'(addr_dout));
        if (first_en_k < 0) first_en_k = k;
      end
      if (step_valid && first_valid_k < 0) first_valid_k = k;
      if (done) begin
        done_k = k;
        err_done = error;
        break;
      end
      if (step_valid && stall_left > 0) begin
        if (stall_left == stall) begin
          h_op = step_op; h_i = step_i; h_j = step_j;
        end else begin
          chk("bp_op_stable", step_op, h_op);
          chk("bp_i_stable", step_i, h_i);
          chk("bp_j_stable", step_j, h_j);
        end
        chk("bp_no_read", en_dout, 1'b0);
        step_ready = 1'b0;
        stall_left--;
      end else begin
        step_ready = 1'b1;
        if (step_valid) begin
          acc_op.push_back(int'(step_op));
          acc_i.push_back(int'(step_i));
          acc_j.push_back(int'(step_j));
          acc_k.push_back(k);
        end
      end
    end
    start = 1'b0;
    step_ready = 1'b1;
    chk("walk_done_seen", done_k >= 0, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    step_ready = 1'b1;
    fill(3'b001);
    repeat (3) @(posedge clk);
    @(negedge clk);
    // Reset state
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_error", error, 1'b0);
    chk("rst_valid", step_valid, 1'b0);
    chk("rst_en", en_dout, 1'b0);
    chk("rst_addr", addr_dout, 0);
    chk("rst_op", step_op, 0);
    rst_n = 1'b1;

    // All DIAG
    fill(3'b001);
    walk(0, 0);
    chk("diag_nsteps", acc_op.size(), 4);
    chk("diag_nreads", rd_addr.size(), 4);
    for (int s = 0; s < 4; s++) begin
      chk("diag_addr", rd_addr[s], 24 - 6 * s);
      chk("diag_op", acc_op[s], 0);
      chk("diag_i", acc_i[s], 4 - s);
      chk("diag_j", acc_j[s], 4 - s);
    end
    chk("diag_first_en", first_en_k, 1);
    chk("diag_first_valid", first_valid_k, 3);
    chk("diag_throughput", acc_k[1] - acc_k[0], 3);
    chk("diag_done_lat", done_k - acc_k[3], 1);
    chk("diag_error", err_done, 1'b0);
    @(negedge clk);
    chk("diag_done_pulse", done, 1'b0);
    chk("diag_idle_busy", busy, 1'b0);

    // All LEFT: four LEFT moves, then forced UP along column 0
    fill(3'b100);
    walk(0, 0);
    chk("left_nsteps", acc_op.size(), 8);
    chk("left_nreads", rd_addr.size(), 8);
    for (int s = 0; s < 4; s++) begin
      chk("left_op", acc_op[s], 2);
      chk("left_i", acc_i[s], 4);
      chk("left_j", acc_j[s], 4 - s);
      chk("left_addr", rd_addr[s], 24 - s);
    end
    for (int s = 4; s < 8; s++) begin
      chk("col0_op", acc_op[s], 1);
      chk("col0_i", acc_i[s], 8 - s);
      chk("col0_j", acc_j[s], 0);
      chk("col0_addr", rd_addr[s], (8 - s) * 5);
    end
    chk("left_error", err_done, 1'b0);

    // Priority: all flags set at (4,4)
    fill(3'b001);
    mem[24] = 3'b111;
    walk(0, 0);
    chk("prio_first_op", acc_op[0], 0);
    chk("prio_nsteps", acc_op.size(), 4);

    // Backpressure on the first EMIT
    fill(3'b001);
    walk(5, 0);
    chk("bp_nsteps", acc_op.size(), 4);
    chk("bp_first_accept", acc_k[0], 8);
    chk("bp_second_addr", rd_addr[1], 18);
    chk("bp_op0", acc_op[0], 0);

    // Empty code at (2,2)
    fill(3'b001);
    mem[12] = 3'b000;
    walk(0, 0);
    chk("err_nsteps", acc_op.size(), 2);
    chk("err_i1", acc_i[1], 3);
    chk("err_nreads", rd_addr.size(), 3);
    chk("err_flag", err_done, 1'b1);
    @(negedge clk);
    chk("err_sticky", error, 1'b1);
    chk("err_idle", busy, 1'b0);
    fill(3'b001);
    walk(0, 0);
    chk("err_cleared_on_start", err_k1, 1'b0);
    chk("err_clear_run", err_done, 1'b0);
    chk("err_clear_nsteps", acc_op.size(), 4);

    // Asynchronous reset while a step is offered
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    step_ready = 1'b0;
    for (int c = 0; c < 10 && !step_valid; c++) @(negedge clk);
    chk("mid_valid_before", step_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", step_valid, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_i", step_i, 0);
    chk("mid_rst_j", step_j, 0);
    chk("mid_rst_en", en_dout, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    repeat (2) @(negedge clk);
    chk("mid_rst_no_read", en_dout, 1'b0);
    rst_n = 1'b1;
    step_ready = 1'b1;
    // Restart after reset, with a stray start while busy
    walk(0, 5);
    chk("restart_addr0", rd_addr[0], 24);
    chk("restart_nsteps", acc_op.size(), 4);
    chk("restart_nreads", rd_addr.size(), 4);
    chk("restart_addr3", rd_addr[3], 6);
    @(negedge clk);
    chk("restart_idle", busy, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
